fifo_rr_ctrl: RTL and testbench

- Controller that shares a single-clock FIFO instance between NUM_REQ write requesters using round-robin arbitration.
- Sequences FIFO reads into a registered valid/ready output stream for a downstream consumer, e.g. a MAC stage.
- Tracks FIFO occupancy internally because the FIFO wrapper exposes only full/empty.
- Sits between producer blocks and the FIFO wrapper's wren/rden/i_data/o_data pins.

---
 rtl/fifo_rr_pkg.sv | 22 ++
 rtl/fifo_rr_ctrl_if.sv | 46 ++++
 rtl/fifo_rr_ctrl_arbiter.sv | 41 ++++
 rtl/fifo_rr_ctrl.sv | 140 ++++++++++++++
 tb/tb_fifo_rr_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rr_pkg.sv
// rtl/fifo_rr_pkg.sv - shared types, constants and helpers for fifo_rr_ctrl
package fifo_rr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        HOLD = 2'd2
    } rd_state_t;

    localparam int STAT_W  = 16;
    localparam int MAX_REQ = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_rr_ctrl_if.sv
// rtl/fifo_rr_ctrl_if.sv - requester, FIFO-pin and output-stream bundle for fifo_rr_ctrl
// FIFO_RR_STATS_EN adds the grant_cnt/stall_cnt statistics signals.
interface fifo_rr_ctrl_if
    import fifo_rr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int NUM_REQ    = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wren;
    logic [DATA_WIDTH-1:0]         fifo_wdata;
    logic                          fifo_rden;
    logic [DATA_WIDTH-1:0]         fifo_rdata;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_ready;
    logic [CW-1:0]                 count;
`ifdef FIFO_RR_STATS_EN
    logic [NUM_REQ*STAT_W-1:0]     grant_cnt;
    logic [STAT_W-1:0]             stall_cnt;
`endif

    modport master (
        input  req_valid, req_data, fifo_rdata, fifo_full, fifo_empty, out_ready,
        output req_ready, fifo_wren, fifo_wdata, fifo_rden, out_valid, out_data, count
`ifdef FIFO_RR_STATS_EN
        , output grant_cnt, stall_cnt
`endif
    );

    modport slave (
        output req_valid, req_data, fifo_rdata, fifo_full, fifo_empty, out_ready,
        input  req_ready, fifo_wren, fifo_wdata, fifo_rden, out_valid, out_data, count
`ifdef FIFO_RR_STATS_EN
        , input grant_cnt, stall_cnt
`endif
    );

endinterface

// File: rtl/fifo_rr_ctrl_arbiter.sv
// rtl/fifo_rr_ctrl_arbiter.sv - rr_arbiter: combinational round-robin grant with rotating pointer
module rr_arbiter
    import fifo_rr_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [N-1:0]  mask;
    logic [N-1:0]  hi;
    logic [N-1:0]  pick;
    logic [2:0]    gidx;

    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        hi    = req & mask;
        pick  = (|hi) ? hi : req;
        grant = en ? (pick & (~pick + N'(1))) : '0;
        gidx  = onehot_to_idx(MAX_REQ'(grant));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (gidx == 3'(N - 1)) ? '0 : PW'(gidx + 3'd1);
        end
    end

endmodule

// File: rtl/fifo_rr_ctrl.sv
// rtl/fifo_rr_ctrl.sv - round-robin FIFO write sharing plus registered read stream
// FIFO_RR_STATS_EN adds saturating grant_cnt/stall_cnt counters.
module fifo_rr_ctrl
    import fifo_rr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fifo_rr_ctrl_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_REQ-1:0]    grant;
    logic                  can_wr;
    logic                  wren;
    logic                  rden;
    logic [DATA_WIDTH-1:0] wdata;
    logic [CW-1:0]         count;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    rd_state_t             state;
    rd_state_t             next_state;

    assign can_wr = !bus.fifo_full && (count < CW'(DEPTH));

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.req_valid),
        .en    (can_wr && !rst),
        .grant (grant)
    );

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) wdata = wdata | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign wren = |grant;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Reads also require !fifo_empty so a flag/count disagreement can never underflow the FIFO.
    always_comb begin
        next_state = state;
        rden       = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (count != '0 && !bus.fifo_empty) begin
                        rden       = 1'b1;
                        next_state = CAPT;
                    end
                end
                CAPT: next_state = HOLD;
                HOLD: begin
                    if (bus.out_ready) begin
                        if (count != '0 && !bus.fifo_empty) begin
                            rden       = 1'b1;
                            next_state = CAPT;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (state == CAPT) begin
            out_valid <= 1'b1;
            out_data  <= bus.fifo_rdata;
        end else if (state == HOLD && bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({wren, rden})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_RR_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] grant_cnt;
    logic [STAT_W-1:0]         stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && grant_cnt[i*STAT_W +: STAT_W] != '1) begin
                    grant_cnt[i*STAT_W +: STAT_W] <= grant_cnt[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
            if (|bus.req_valid && !can_wr && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
        end
    end

    assign bus.grant_cnt = grant_cnt;
    assign bus.stall_cnt = stall_cnt;
`endif

    assign bus.req_ready  = grant;
    assign bus.fifo_wren  = wren;
    assign bus.fifo_wdata = wdata;
    assign bus.fifo_rden  = rden;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data;
    assign bus.count      = count;

    a_no_wr_full: assert property (@(posedge clk) disable iff (rst) !(wren && bus.fifo_full));
    a_no_rd_empty: assert property (@(posedge clk) disable iff (rst) !(rden && bus.fifo_empty));
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !bus.out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// tb/tb_fifo_rr_ctrl.sv - directed scoreboard bench for fifo_rr_ctrl with a behavioural FIFO
module tb_fifo_rr_ctrl;
    import fifo_rr_pkg::*;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int NR = 2;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [7:0] sb[$];
    logic [7:0] a_word, b_word;

    fifo_rr_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_REQ(NR)) bus ();

    fifo_rr_ctrl #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, flags from its own occupancy.
    logic [7:0] mem [DP];
    logic [2:0] wp, rp;
    logic [3:0] occ;

    always @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            occ <= '0;
            bus.fifo_rdata <= '0;
        end else begin
            if (bus.fifo_wren) begin
                mem[wp] <= bus.fifo_wdata;
                wp <= wp + 3'd1;
            end
            if (bus.fifo_rden) begin
                bus.fifo_rdata <= mem[rp];
                rp <= rp + 3'd1;
            end
            occ <= occ + {3'd0, bus.fifo_wren} - {3'd0, bus.fifo_rden};
        end
    end

    assign bus.fifo_full  = (occ == 4'd8);
    assign bus.fifo_empty = (occ == 4'd0);
    assign bus.req_data   = {b_word, a_word};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pushes the bench-driven word of each granted requester, pops on output handshake.
    logic       hold_v = 1'b0;
    logic [7:0] held;
    logic [7:0] exp_w;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (|bus.req_ready) begin
                exp_w = bus.req_ready[1] ? b_word : a_word;
                check("wdata", {24'd0, bus.fifo_wdata}, {24'd0, exp_w});
                sb.push_back(exp_w);
            end
            if (hold_v && bus.out_valid) check("stable", {24'd0, bus.out_data}, {24'd0, held});
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $error("FAIL sb_order: observed %0h expected none", bus.out_data);
                end else begin
                    exp_w = sb.pop_front();
                    check("sb_order", {24'd0, bus.out_data}, {24'd0, exp_w});
                end
            end
            hold_v = bus.out_valid && !bus.out_ready;
            held   = bus.out_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int i;
        bus.out_ready = 1'b1;
        for (i = 0; i < 60 && !(bus.count == '0 && !bus.out_valid && sb.size() == 0); i++) begin
            @(negedge clk);
        end
        check(tag, {31'd0, (bus.count == '0 && !bus.out_valid && sb.size() == 0)}, 32'd1);
        cyc();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [1:0] g;
        int nb;
        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.out_ready = 1'b0;
        a_word = 8'h10;
        b_word = 8'h20;

        // Reset with both requesters pending
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ready", {30'd0, bus.req_ready}, 32'd0);
            check("rst_wren", {31'd0, bus.fifo_wren}, 32'd0);
            check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
            check("rst_count", {28'd0, bus.count}, 32'd0);
        end
        cyc();
        rst = 1'b0;

        // Fairness: grants alternate starting at requester 0
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g = bus.req_ready;
            check("fair_grant", {30'd0, g}, (i % 2 == 0) ? 32'd1 : 32'd2);
            cyc();
            if (g[0]) a_word++;
            if (g[1]) b_word++;
        end
        bus.req_valid = 2'b01;
        check("fair_count", {28'd0, bus.count}, 32'd5);

        // Fill to full, then stall
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fill_grant", {30'd0, bus.req_ready}, 32'd1);
            cyc();
            a_word++;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("full_count", {28'd0, bus.count}, 32'd8);
            check("full_stall", {30'd0, bus.req_ready}, 32'd0);
            check("full_wren", {31'd0, bus.fifo_wren}, 32'd0);
            check("full_head", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'h10});
            cyc();
        end
        bus.req_valid = 2'b00;
        drain("full_drain");

        // Latency from a single write into an empty FIFO
        a_word = 8'h5A;
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("lat_wr", {29'd0, bus.req_ready, bus.fifo_rden}, {29'd0, 2'b01, 1'b0});
        cyc();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("lat_rden", {31'd0, bus.fifo_rden}, 32'd1);
        cyc();
        @(negedge clk);
        check("lat_capt", {30'd0, bus.out_valid, bus.fifo_rden}, 32'd0);
        cyc();
        @(negedge clk);
        check("lat_out", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'h5A});
        cyc();
        drain("lat_drain");

        // Backpressure: consumer toggles ready every cycle
        b_word = 8'h30;
        nb = 0;
        for (int i = 0; i < 24; i++) begin
            bus.out_ready = (i % 2 == 0);
            bus.req_valid = (nb < 4) ? 2'b10 : 2'b00;
            @(negedge clk);
            g = bus.req_ready;
            cyc();
            if (g[1]) begin
                b_word++;
                nb++;
            end
        end
        check("bp_words", nb, 32'd4);
        bus.req_valid = 2'b00;
        drain("bp_drain");

        // Simultaneous write and read at count=3
        a_word = 8'h40;
        bus.req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sim_fill", {30'd0, bus.req_ready}, 32'd1);
            cyc();
            a_word++;
        end
        bus.req_valid = 2'b00;
        cyc();
        @(negedge clk);
        check("sim_pre", {27'd0, bus.out_valid, bus.count}, {27'd0, 1'b1, 4'd3});
        cyc();
        bus.req_valid = 2'b01;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("sim_both", {30'd0, bus.fifo_wren, bus.fifo_rden}, 32'd3);
        cyc();
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("sim_count", {28'd0, bus.count}, 32'd3);
        cyc();

        // Reset pulse while holding an output word
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_hold_gate", {29'd0, bus.req_ready, bus.fifo_rden}, 32'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {27'd0, bus.out_valid, bus.count}, 32'd0);
        check("rst_mid_state", {30'd0, dut.state}, {30'd0, IDLE});
        check("rst_mid_rden", {31'd0, bus.fifo_rden}, 32'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
